mux_pipe_n: RTL
===============

Name: mux_pipe_n

Overview:
- Parametrised successor to the datapath operand selector.
- Selects one of NUM_IN WIDTH-bit inputs using a binary selector.
- Registers the result behind a valid/ready handshake, with a 2-entry (output + skid) buffer for full throughput under backpressure.
- Sits between the register-file/immediate/PC sources and the ALU/memory stages of the 64-bit datapath. Out-of-range selectors are flagged instead of silently zeroed.

Parameters:
- WIDTH, 64, data width of each input and the output.
- NUM_IN, 4, number of data inputs; must be >= 2.
- SEL_W, 3, selector width; must satisfy 2**SEL_W >= NUM_IN.
- DEFAULT_VAL, 64'd0, output value for an out-of-range selector; truncated/zero-extended to WIDTH.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream offers sel/in_data this cycle.
- in_ready  out  1  block can accept this cycle.
- sel  in  SEL_W  binary selector; sampled only on accept.
- in_data  in  NUM_IN x WIDTH  packed array [NUM_IN-1:0][WIDTH-1:0]; element i is input i.
- out_valid  out  1  out_data/out_sel_err hold a valid result.
- out_ready  in  1  downstream consumes this cycle.
- out_data  out  WIDTH  selected value.
- out_sel_err  out  1  result came from sel >= NUM_IN.
- err_count  out  16  out-of-range select count (see Optional Feature).

Behaviour:
- Reset: one clock, synchronous and active-low, as already decided.
  - While rst_n=0 on a rising edge: out_valid=0, out_data=0, out_sel_err=0, skid empty, err_count=0.
  - in_ready=0 combinationally while rst_n=0.
  - Reset mid-transfer discards both entries; nothing is replayed.
- Accept: when in_valid && in_ready, compute sel_val = (sel < NUM_IN) ? in_data[sel] : DEFAULT_VAL and err = (sel >= NUM_IN). Non-selected inputs are don't-care.
- Consume: when out_valid && out_ready.
- in_ready = rst_n && !skid_valid, driven from a register with no combinational path from out_ready.
- Next state of the output register:
  - Empty or consuming, skid empty, accept: load {sel_val, err}; out_valid=1.
  - Empty or consuming, skid full: load the skid entry; skid empties (no accept is possible, since in_ready=0).
  - Consuming, no accept, skid empty: out_valid=0; out_data holds its last value.
  - Full, not consuming, accept: the entry goes to skid; skid_valid=1; in_ready=0 from the next cycle.
  - Full, not consuming, no accept: hold.
- Stability: out_data and out_sel_err are stable while out_valid && !out_ready.
- Latency: 1 cycle from accept to out_valid when the output stage is empty.
- Throughput: 1 result/cycle with out_ready held at 1.
- Ordering is strictly FIFO; capacity is 2 entries.
- Simultaneous accept and consume with the skid empty is a pass-through reload at full rate. This case cannot occur with the skid full.
- Elaboration-time assertion fails if NUM_IN < 2 or 2**SEL_W < NUM_IN.

Optional Feature:
- Macro: MUX_PIPE_N_ERRCNT_EN.
- Defined: err_count increments by 1 on each accept with sel >= NUM_IN. It saturates at 16'hFFFF and clears only on reset.
- Undefined: err_count is tied to 16'd0 and no counter logic exists. out_sel_err behaves identically in both builds.

Decomposition:
- Package mux_pipe_pkg holds:
  - word_t (logic [63:0]);
  - ERRCNT_W = 16;
  - typedef entry_t struct packed {data, sel_err} parameterised via WIDTH in the module.
- One sub-module is natural: mux_sel_n, the purely combinational NUM_IN:1 selector with the range check and DEFAULT_VAL, producing {sel_val, err}.
- The top holds the output register, the skid register, handshake logic and the optional counter.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_data=0, err_count=0. Release -> in_ready=1 next cycle.
- Pass-through: out_ready=1; in_data={4,3,2,1} (64'h...); sel=2 then 0 then 3 on consecutive cycles -> out_data=3,1,4 on cycles +1,+2,+3; out_valid continuous; out_sel_err=0.
- Out-of-range: sel=3'd5, in_data arbitrary -> out_data=0, out_sel_err=1. With MUX_PIPE_N_ERRCNT_EN, err_count=1; repeated 3 times -> err_count=3.
- Backpressure: out_ready=0; push sel=0 (A=64'hAAAA) then sel=1 (B=64'hBBBB) -> in_ready=0 after the 2nd accept; out_data stays 64'hAAAA. Raise out_ready -> AAAA then BBBB; in_ready=1 again one cycle after the skid drains.
- Reset mid-operation: both entries full; assert rst_n=0 for 1 cycle -> out_valid=0, skid empty; neither entry ever appears on the output.
- Saturation (macro on): force err_count to 16'hFFFE, send 3 out-of-range selects -> err_count=16'hFFFF and holds.

Source files
------------

// File: rtl/mux_pipe_pkg.sv
// mux_pipe_pkg: shared word type, counter width and helpers
// for the mux_pipe_n operand selector.
package mux_pipe_pkg;

  localparam int WORD_W   = 64;
  localparam int ERRCNT_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  function automatic logic [ERRCNT_W-1:0] sat_inc(
    input logic [ERRCNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mux_pipe_n_sel.sv
// mux_sel_n: combinational NUM_IN:1 selector with range check.
// Out-of-range selectors return DEFAULT_VAL and raise o_err.
module mux_sel_n
  import mux_pipe_pkg::*;
#(
  parameter int    WIDTH       = 64,
  parameter int    NUM_IN      = 4,
  parameter int    SEL_W       = 3,
  parameter word_t DEFAULT_VAL = '0
) (
  input  logic [SEL_W-1:0]              i_sel,
  input  logic [NUM_IN-1:0][WIDTH-1:0]  i_in_data,
  output logic [WIDTH-1:0]              o_sel_val,
  output logic                          o_err
);

  localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_VAL);

  assign o_err = (32'(i_sel) >= NUM_IN);

  // pick the addressed input, falling back to the default value
  always_comb begin
    o_sel_val = DEF;
    for (int i = 0; i < NUM_IN; i++) begin
      if (32'(i_sel) == i) o_sel_val = i_in_data[i];
    end
  end

endmodule

// File: rtl/mux_pipe_n.sv
// mux_pipe_n: registered NUM_IN:1 selector with skid buffer.
// Optional saturating error counter: MUX_PIPE_N_ERRCNT_EN.
module mux_pipe_n
  import mux_pipe_pkg::*;
#(
  parameter int    WIDTH       = 64,
  parameter int    NUM_IN      = 4,
  parameter int    SEL_W       = 3,
  parameter word_t DEFAULT_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SEL_W-1:0]              sel,
  input  logic [NUM_IN-1:0][WIDTH-1:0]  in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic                          out_sel_err,
  output logic [ERRCNT_W-1:0]           err_count
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             sel_err;
  } entry_t;

  if (NUM_IN < 2 || (2 ** SEL_W) < NUM_IN) begin : g_cfg_bad
    $error("mux_pipe_n: NUM_IN must be >= 2 and fit in SEL_W");
  end

  logic [WIDTH-1:0] w_val;
  logic             w_err;
  entry_t           w_new;
  logic             w_acc;
  logic             w_cons;

  entry_t r_out;
  logic   r_out_valid;
  entry_t r_skid;
  logic   r_skid_valid;

  mux_sel_n #(
    .WIDTH       (WIDTH),
    .NUM_IN      (NUM_IN),
    .SEL_W       (SEL_W),
    .DEFAULT_VAL (DEFAULT_VAL)
  ) u_sel (
    .i_sel     (sel),
    .i_in_data (in_data),
    .o_sel_val (w_val),
    .o_err     (w_err)
  );

  assign w_new    = '{data: w_val, sel_err: w_err};
  assign in_ready = rst_n && !r_skid_valid;
  assign w_acc    = in_valid && in_ready;
  assign w_cons   = r_out_valid && out_ready;

  assign out_valid   = r_out_valid;
  assign out_data    = r_out.data;
  assign out_sel_err = r_out.sel_err;

  // output stage + skid: 2-entry FIFO, skid drains first
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out        <= '0;
      r_out_valid  <= 1'b0;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
    end else if (!r_out_valid || w_cons) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_acc) begin
        r_out       <= w_new;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_acc) begin
      r_skid       <= w_new;
      r_skid_valid <= 1'b1;
    end
  end

`ifdef MUX_PIPE_N_ERRCNT_EN
  logic [ERRCNT_W-1:0] r_err_cnt;

  // count accepted out-of-range selects, saturating
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (w_acc && w_err) begin
      r_err_cnt <= sat_inc(r_err_cnt);
    end
  end

  assign err_count = r_err_cnt;
`else
  assign err_count = '0;
`endif

endmodule
